// File: rtl/l1_dcache_miss_handler.sv
// -----------------------------------------------------------------------------
// l1_dcache_miss_handler
//   Refill / write-back engine beside the L1 data cache.
//   On a miss it optionally writes the dirty victim block to the next level,
//   then fetches the missing block critical-word-first, wrapping inside the
//   block, and streams each returned word straight into the L1 line.
//   One word moves per next-level handshake (mem_req && mem_ack).
// -----------------------------------------------------------------------------
module l1_dcache_miss_handler #(
  parameter  int ADDR_W      = 16,
  parameter  int WORD_W      = 16,
  parameter  int BLOCK_WORDS = 8,
  localparam int OFF_W       = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  // L1 miss path
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic [OFF_W-1:0]  victim_rd_idx,
  input  logic [WORD_W-1:0] victim_rd_data,
  output logic              miss_busy,
  // L1 line refill port
  output logic              fill_we,
  output logic [OFF_W-1:0]  fill_idx,
  output logic [WORD_W-1:0] fill_data,
  output logic              fill_done,
  // next-level (L2 / memory) port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Mask selecting the word-offset bits of a word address
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BLOCK_WORDS - 1);
  localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

  logic [1:0]        r_state;
  logic [OFF_W-1:0]  r_cnt;        // words transferred in the current phase
  logic [ADDR_W-1:0] r_miss_addr;  // full miss address; low bits = critical word
  logic [ADDR_W-1:0] r_vict_addr;  // victim address; low bits are replaced by r_cnt

  logic              w_xfer;       // one word handshake completes this cycle
  logic              w_last;       // current word is the last of the block
  logic [OFF_W-1:0]  w_fill_off;   // wrapped fill offset, critical word first
  logic [ADDR_W-1:0] w_wb_addr;
  logic [ADDR_W-1:0] w_fill_addr;

  // Address/handshake helpers shared by the FSM and the output decode
  assign w_xfer      = mem_req & mem_ack;
  assign w_last      = (r_cnt == LAST_WORD);
  // Offset add is OFF_W bits wide so it wraps inside the block and never
  // carries into the tag/index bits of the address.
  assign w_fill_off  = r_miss_addr[OFF_W-1:0] + r_cnt;
  assign w_wb_addr   = (r_vict_addr & ~OFF_MASK) | ADDR_W'(r_cnt);
  assign w_fill_addr = (r_miss_addr & ~OFF_MASK) | ADDR_W'(w_fill_off);

  // State, word counter and latched miss/victim addresses
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_miss_addr <= '0;
      r_vict_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_req) begin
            r_miss_addr <= miss_addr;
            r_vict_addr <= victim_addr;
            r_cnt       <= '0;
            r_state     <= victim_dirty ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (w_xfer) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_FILL;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end
        default: begin
          // S_DONE: fill_done has been shown for this one cycle
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: purely a function of state, counter and same-cycle inputs,
  // so a mid-operation reset drops mem_req without waiting for a clock edge.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    miss_busy     = (r_state != S_IDLE);
    victim_rd_idx = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    fill_we       = 1'b0;
    fill_idx      = '0;
    fill_data     = '0;
    fill_done     = 1'b0;
    case (r_state)
      S_WB: begin
        // Held stable while mem_ack is low because r_cnt only moves on an ack
        victim_rd_idx = r_cnt;
        mem_req       = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = w_wb_addr;
        mem_wdata     = victim_rd_data;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = w_fill_addr;
        if (mem_ack) begin
          fill_we   = 1'b1;
          fill_idx  = w_fill_off;
          fill_data = mem_rdata;
        end
      end
      S_DONE: begin
        fill_done = 1'b1;
      end
      default: begin
        // S_IDLE: everything stays at its default
      end
    endcase
  end

endmodule

// File: tb/tb_l1_dcache_miss_handler.sv
// -----------------------------------------------------------------------------
// tb_l1_dcache_miss_handler
//   Directed vector table for zero-wait-state clean/dirty/wrapping misses,
//   plus hand-written sequences for wait states, mid-operation reset and
//   ignored miss_req / mem_ack.
//   Victim line model: word i = 0xA000 + i.
//   Memory read model: rdata = addr ^ 0x5A5A.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l1_dcache_miss_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_req;
  logic [15:0] miss_addr;
  logic        victim_dirty;
  logic [15:0] victim_addr;
  logic [2:0]  victim_rd_idx;
  logic [15:0] victim_rd_data;
  logic        miss_busy;
  logic        fill_we;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;
  logic        fill_done;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  l1_dcache_miss_handler dut (
    .clk            (clk),
    .reset          (reset),
    .miss_req       (miss_req),
    .miss_addr      (miss_addr),
    .victim_dirty   (victim_dirty),
    .victim_addr    (victim_addr),
    .victim_rd_idx  (victim_rd_idx),
    .victim_rd_data (victim_rd_data),
    .miss_busy      (miss_busy),
    .fill_we        (fill_we),
    .fill_idx       (fill_idx),
    .fill_data      (fill_data),
    .fill_done      (fill_done),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment models
  assign victim_rd_data = 16'hA000 | {13'd0, victim_rd_idx};
  assign mem_rdata      = mem_addr ^ 16'h5A5A;

  typedef struct {
    // inputs
    logic        req;
    logic [15:0] addr;
    logic        dirty;
    logic [15:0] vaddr;
    logic        ack;
    // expected outputs
    logic        busy;
    logic        mreq;
    logic        mwe;
    logic [15:0] maddr;
    logic [15:0] mwdata;
    logic        fwe;
    logic [2:0]  fidx;
    logic        fdone;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_in(input logic req, input logic [15:0] a, input logic d,
                                 input logic [15:0] va, input logic ack);
    vec_t v;
    v.req = req; v.addr = a; v.dirty = d; v.vaddr = va; v.ack = ack;
    v.busy = 1'b0; v.mreq = 1'b0; v.mwe = 1'b0; v.maddr = 16'h0; v.mwdata = 16'h0;
    v.fwe = 1'b0; v.fidx = 3'd0; v.fdone = 1'b0;
    return v;
  endfunction

  task automatic add_idle(input logic req, input logic [15:0] a, input logic d,
                          input logic [15:0] va, input logic ack);
    vecs.push_back(mk_in(req, a, d, va, ack));
  endtask

  task automatic add_wb(input logic [15:0] a, input logic [15:0] wd);
    vec_t v = mk_in(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    v.busy = 1'b1; v.mreq = 1'b1; v.mwe = 1'b1; v.maddr = a; v.mwdata = wd;
    vecs.push_back(v);
  endtask

  task automatic add_fill(input logic [15:0] a, input logic [2:0] idx);
    vec_t v = mk_in(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    v.busy = 1'b1; v.mreq = 1'b1; v.maddr = a; v.fwe = 1'b1; v.fidx = idx;
    vecs.push_back(v);
  endtask

  task automatic add_done();
    vec_t v = mk_in(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    v.busy = 1'b1; v.fdone = 1'b1;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic req, input logic [15:0] a, input logic d,
                       input logic [15:0] va, input logic ack);
    miss_req = req; miss_addr = a; victim_dirty = d; victim_addr = va; mem_ack = ack;
  endtask

  // Advance to just after the next active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"},      miss_busy,     0);
    check({tag, " mem_req"},   mem_req,       0);
    check({tag, " mem_we"},    mem_we,        0);
    check({tag, " mem_addr"},  mem_addr,      0);
    check({tag, " mem_wdata"}, mem_wdata,     0);
    check({tag, " fill_we"},   fill_we,       0);
    check({tag, " fill_idx"},  fill_idx,      0);
    check({tag, " fill_data"}, fill_data,     0);
    check({tag, " fill_done"}, fill_done,     0);
    check({tag, " vrd_idx"},   victim_rd_idx, 0);
  endtask

  // Ack every cycle until fill_done; counts fills seen before it (bounded)
  task automatic run_to_done(input string tag, input int exp_fills);
    int  fills = 0;
    bit  seen  = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      @(negedge clk);
      if (fill_done) begin
        seen = 1;
        break;
      end
      if (fill_we) fills++;
      step();
    end
    check({tag, " fill_done seen"}, 32'(seen), 1);
    check({tag, " fill count"}, fills, exp_fills);
    step();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check({tag, " idle after done"}, miss_busy, 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector table ----------------
    // 1. clean miss 0x1235, ack always (ack in IDLE ignored)
    add_idle(1'b1, 16'h1235, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] o;
      o = 3'(5 + k);
      add_fill(16'h1230 | {13'd0, o}, o);
    end
    add_done();
    add_idle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    // 2. dirty miss, victim 0x0043 (offset bits ignored), miss 0x2000
    add_idle(1'b1, 16'h2000, 1'b1, 16'h0043, 1'b1);
    for (int k = 0; k < 8; k++) add_wb(16'h0040 + 16'(k), 16'hA000 + 16'(k));
    for (int k = 0; k < 8; k++) add_fill(16'h2000 + 16'(k), 3'(k));
    add_done();
    add_idle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    // 6. miss 0xFFFF wraps inside the block
    add_idle(1'b1, 16'hFFFF, 1'b0, 16'h0, 1'b1);
    add_fill(16'hFFFF, 3'd7);
    for (int k = 0; k < 7; k++) add_fill(16'hFFF8 + 16'(k), 3'(k));
    add_done();
    add_idle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

    // ---------------- reset ----------------
    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check_zero("reset");
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check_zero("post-reset");
    step();

    // ---------------- table-driven ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v = vecs[i];
      drive(v.req, v.addr, v.dirty, v.vaddr, v.ack);
      @(negedge clk);
      check($sformatf("vec%0d busy", i),      miss_busy, v.busy);
      check($sformatf("vec%0d mem_req", i),   mem_req,   v.mreq);
      check($sformatf("vec%0d mem_we", i),    mem_we,    v.mwe);
      check($sformatf("vec%0d mem_addr", i),  mem_addr,  v.maddr);
      check($sformatf("vec%0d mem_wdata", i), mem_wdata, v.mwdata);
      check($sformatf("vec%0d fill_we", i),   fill_we,   v.fwe);
      check($sformatf("vec%0d fill_idx", i),  fill_idx,  v.fidx);
      check($sformatf("vec%0d fill_data", i), fill_data, v.fwe ? (v.maddr ^ 16'h5A5A) : 16'h0);
      check($sformatf("vec%0d fill_done", i), fill_done, v.fdone);
      step();
    end

    // ---------------- 3. wait states: ack every 3rd cycle ----------------
    begin
      int acks  = 0;
      bit seen  = 0;
      drive(1'b1, 16'h0AB2, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      step();
      for (int c = 0; c < 60; c++) begin
        logic ack;
        logic [2:0] o;
        ack = ((c % 3) == 2);
        o = 3'(2 + acks);
        drive(1'b0, 16'h0, 1'b0, 16'h0, ack);
        @(negedge clk);
        if (fill_done) begin
          seen = 1;
          check("t3 done mem_req", mem_req, 0);
          break;
        end
        check($sformatf("t3 c%0d mem_req", c),  mem_req,  1);
        check($sformatf("t3 c%0d mem_addr", c), mem_addr, 16'h0AB0 | {13'd0, o});
        check($sformatf("t3 c%0d fill_we", c),  fill_we,  ack);
        if (ack) begin
          check($sformatf("t3 c%0d fill_idx", c), fill_idx, o);
          acks++;
        end
        step();
      end
      check("t3 fill_done seen", 32'(seen), 1);
      check("t3 acks before done", acks, 8);
      step();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      check("t3 idle busy", miss_busy, 0);
      step();
    end

    // ---------------- 4. reset mid-WB after 3 acks ----------------
    drive(1'b1, 16'h4444, 1'b1, 16'h0100, 1'b1);
    @(negedge clk);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      @(negedge clk);
      check($sformatf("t4 wb%0d mem_we", k), mem_we, 1);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    #2;
    check("t4 wb hold addr", mem_addr, 16'h0103);
    check("t4 wb hold data", mem_wdata, 16'hA003);
    reset = 1'b1;
    #1;
    check_zero("t4 async reset");
    step();
    reset = 1'b0;
    drive(1'b1, 16'h3004, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check("t4 new miss idle busy", miss_busy, 0);
    check("t4 no fill_done", fill_done, 0);
    step();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    check("t4 first fill mem_we", mem_we, 0);
    check("t4 first fill addr", mem_addr, 16'h3004);
    check("t4 first fill we", fill_we, 1);
    check("t4 first fill idx", fill_idx, 4);
    step();
    run_to_done("t4", 7);

    // ---------------- 5. miss_req during FILL, mem_ack in IDLE ----------------
    drive(1'b1, 16'h5553, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    step();
    drive(1'b1, 16'h7777, 1'b1, 16'h0200, 1'b0);
    @(negedge clk);
    check("t5 fill addr under miss_req", mem_addr, 16'h5553);
    check("t5 busy under miss_req", miss_busy, 1);
    check("t5 no fill under miss_req", fill_we, 0);
    step();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check("t5 addr after miss_req", mem_addr, 16'h5553);
    check("t5 still a read", mem_we, 0);
    step();
    run_to_done("t5", 8);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    check("t5 idle ack mem_req", mem_req, 0);
    check("t5 idle ack fill_we", fill_we, 0);
    check("t5 idle ack busy", miss_busy, 0);
    step();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check("t5 idle stays idle", miss_busy, 0);
    check("t5 idle no done", fill_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
